// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared definitions for the pipelined adder/subtractor.
//   op_t            2-bit operation code carried on the request bus
//   OP_ADD/SUB/ADC/SBC  operation encodings
//   op_inverts_b()  1 when operand B enters the adder inverted
//   op_carry_in()   carry-in seen by the least significant slice
package pipe_adder_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;  // a + b
    localparam op_t OP_SUB = 2'b01;  // a + ~b + 1
    localparam op_t OP_ADC = 2'b10;  // a + b + cin
    localparam op_t OP_SBC = 2'b11;  // a + ~b + cin

    function automatic logic op_inverts_b(input op_t op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    function automatic logic op_carry_in(input op_t op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: request/response bundle of the pipelined adder.
//   in_valid/in_ready   request handshake, payload in_a, in_b, in_op, in_cin
//   out_valid/out_ready response handshake, payload out_sum, out_cout,
//                       out_ovf, out_zero
//   master: the issuing side (drives requests, accepts results)
//   slave:  the adder itself
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The source keeps valid and payload steady until that edge;
// ready may depend combinationally on the sink's state and on its own
// downstream ready, but never on valid.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_t              in_op;
    logic             in_cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/pipe_adder_cla_slice.sv
// cla_slice: combinational SW-bit carry-lookahead adder slice.
//   a, b      slice operands (b already inverted for subtraction)
//   c_in      carry into the slice LSB
//   sum       a + b + c_in modulo 2^SW
//   c_out     carry out of the slice MSB
//   c_msb_in  carry into the slice MSB (used for signed overflow)
module cla_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          c_in,
    output logic [SW-1:0] sum,
    output logic          c_out,
    output logic          c_msb_in
);

    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is an independent sum of products of generate terms and
    // the running propagate chain, so no carry waits on its neighbour:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_in
    always_comb begin
        logic run_p;
        run_p = 1'b0;
        c     = '0;
        c[0]  = c_in;
        for (int i = 0; i < SW; i++) begin
            c[i+1] = g[i];
            run_p  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run_p & g[j]);
                run_p  = run_p & p[j];
            end
            c[i+1] = c[i+1] | (run_p & c_in);
        end
    end

    assign sum      = p ^ c[SW-1:0];
    assign c_out    = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder/subtractor, one SW-bit slice per
// stage, one operation per cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_adder_if slave: in_valid/in_ready with in_a, in_b, in_op,
//          in_cin; out_valid/out_ready with out_sum, out_cout, out_ovf,
//          out_zero (all result fields come straight from the last stage)
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);

    localparam int SW = WIDTH / STAGES;

    // One register per stage. sum holds the slices resolved so far; a and b
    // carry the operands forward so later stages can pick up their slices.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             zacc;
        logic             ovf;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];

    logic [STAGES:0] rdy;
    logic [WIDTH-1:0] b_res;
    logic             c0;

    logic [STAGES-1:0][SW-1:0] sl_a;
    logic [STAGES-1:0][SW-1:0] sl_b;
    logic [STAGES-1:0][SW-1:0] sl_sum;
    logic [STAGES-1:0]         sl_cin;
    logic [STAGES-1:0]         sl_cout;
    logic [STAGES-1:0]         sl_cmsb;

    assign b_res = op_inverts_b(bus.in_op) ? ~bus.in_b : bus.in_b;
    assign c0    = op_carry_in(bus.in_op, bus.in_cin);

    // A stage can take new data when it is empty or its occupant moves on
    // this same edge; evaluated from the output end back to the input.
    always_comb begin
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !st_q[k].valid || rdy[k+1];
        end
    end

    // Slice 0 works on the live request; slice k on what stage k-1 holds.
    always_comb begin
        sl_a[0]   = bus.in_a[SW-1:0];
        sl_b[0]   = b_res[SW-1:0];
        sl_cin[0] = c0;
        for (int k = 1; k < STAGES; k++) begin
            sl_a[k]   = st_q[k-1].a[k*SW +: SW];
            sl_b[k]   = st_q[k-1].b[k*SW +: SW];
            sl_cin[k] = st_q[k-1].carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(
            .SW(SW)
        ) u_slice (
            .a       (sl_a[k]),
            .b       (sl_b[k]),
            .c_in    (sl_cin[k]),
            .sum     (sl_sum[k]),
            .c_out   (sl_cout[k]),
            .c_msb_in(sl_cmsb[k])
        );
    end

    always_comb begin
        st_d[0].valid         = bus.in_valid;
        st_d[0].carry         = sl_cout[0];
        st_d[0].zacc          = (sl_sum[0] == '0);
        st_d[0].ovf           = sl_cmsb[0] ^ sl_cout[0];
        st_d[0].sum           = '0;
        st_d[0].sum[SW-1:0]   = sl_sum[0];
        st_d[0].a             = bus.in_a;
        st_d[0].b             = b_res;
        for (int k = 1; k < STAGES; k++) begin
            st_d[k]                  = st_q[k-1];
            st_d[k].carry            = sl_cout[k];
            st_d[k].zacc             = st_q[k-1].zacc & (sl_sum[k] == '0);
            // Only the last stage's value reaches out_ovf.
            st_d[k].ovf              = sl_cmsb[k] ^ sl_cout[k];
            st_d[k].sum[k*SW +: SW]  = sl_sum[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    st_q[k] <= st_d[k];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = st_q[STAGES-1].valid;
    assign bus.out_sum   = st_q[STAGES-1].sum;
    assign bus.out_cout  = st_q[STAGES-1].carry;
    assign bus.out_ovf   = st_q[STAGES-1].ovf;
    assign bus.out_zero  = st_q[STAGES-1].zacc;

    // Operand copies in the last stage have no further consumer.
    logic unused_tail;
    assign unused_tail = ^{st_q[STAGES-1].a, st_q[STAGES-1].b};

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed bench for pipe_adder. Three instances (STAGES 4, 1
// and 32 at WIDTH 32) share clock and reset; results are packed as
// {ovf, cout, zero, sum}.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int W  = 32;
    localparam int RW = W + 3;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   errors;
    int   checks;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int            cyc_q[$];

    pipe_adder_if #(.WIDTH(W)) bus4 ();
    pipe_adder_if #(.WIDTH(W)) bus1 ();
    pipe_adder_if #(.WIDTH(W)) bus32 ();

    pipe_adder #(.WIDTH(W), .STAGES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    pipe_adder #(.WIDTH(W), .STAGES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipe_adder #(.WIDTH(W), .STAGES(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [RW-1:0] pack_res(input logic ovf, input logic cout,
                                               input logic zero, input logic [W-1:0] sum);
        return {ovf, cout, zero, sum};
    endfunction

    function automatic logic [RW-1:0] res4();
        return {bus4.out_ovf, bus4.out_cout, bus4.out_zero, bus4.out_sum};
    endfunction

    function automatic logic [RW-1:0] res1();
        return {bus1.out_ovf, bus1.out_cout, bus1.out_zero, bus1.out_sum};
    endfunction

    function automatic logic [RW-1:0] res32();
        return {bus32.out_ovf, bus32.out_cout, bus32.out_zero, bus32.out_sum};
    endfunction

    // Flat 33-bit reference; carry into the MSB from a separate 31-bit add.
    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op, input logic cin);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = op[0] ? ~b : b;
        c    = op[1] ? cin : op[0];
        full = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {31'd0, c};
        return pack_res(low[W-1] ^ full[W], full[W], full[W-1:0] == '0, full[W-1:0]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [2:0] vmask, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic cin);
        bus4.in_valid  = vmask[0];
        bus1.in_valid  = vmask[1];
        bus32.in_valid = vmask[2];
        bus4.in_a  = a;  bus1.in_a  = a;  bus32.in_a  = a;
        bus4.in_b  = b;  bus1.in_b  = b;  bus32.in_b  = b;
        bus4.in_op = op; bus1.in_op = op; bus32.in_op = op;
        bus4.in_cin = cin; bus1.in_cin = cin; bus32.in_cin = cin;
    endtask

    // One op into all three instances; each must raise out_valid exactly at
    // its own depth (counting the accept edge as cycle 1) with the result.
    task automatic single_all(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] op, input logic cin, input logic [RW-1:0] exp);
        @(posedge clk); #1;
        drive(3'b111, a, b, op, cin);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'({bus32.in_ready, bus1.in_ready, bus4.in_ready}), 64'(3'b111));
        @(posedge clk); #1;
        drive(3'b000, '0, '0, OP_ADD, 1'b0);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            check($sformatf("%s_v4_c%0d", tag, n),  64'(bus4.out_valid),  64'(n == 4));
            check($sformatf("%s_v1_c%0d", tag, n),  64'(bus1.out_valid),  64'(n == 1));
            check($sformatf("%s_v32_c%0d", tag, n), 64'(bus32.out_valid), 64'(n == 32));
            if (n == 1)  check({tag, "_res1"},  64'(res1()),  64'(exp));
            if (n == 4)  check({tag, "_res4"},  64'(res4()),  64'(exp));
            if (n == 32) check({tag, "_res32"}, 64'(res32()), 64'(exp));
        end
    endtask

    // ---------------- scoreboard capture ----------------
    // At the negedge, out_valid && out_ready means a transfer on the next edge.
    always @(negedge clk) begin
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            got_q.push_back(res4());
            cyc_q.push_back(cyc);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [RW-1:0] held;
        logic          held_seen;
        int            sent;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [1:0]    rop;
        logic          rc;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(3'b000, '0, '0, OP_ADD, 1'b0);
        bus4.out_ready  = 1'b1;
        bus1.out_ready  = 1'b1;
        bus32.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus4.out_valid), 64'(0));
        check("rst_result",    64'(res4()),         64'(0));
        check("rst_in_ready",  64'({bus32.in_ready, bus1.in_ready, bus4.in_ready}), 64'(3'b111));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Hand-computed vectors
        single_all("add",       32'h1234_5678, 32'h0FED_CBA8, OP_ADD, 1'b0, pack_res(1'b0, 1'b0, 1'b0, 32'h2222_2220));
        single_all("sub_eq",    32'hDEAD_BEEF, 32'hDEAD_BEEF, OP_SUB, 1'b0, pack_res(1'b0, 1'b1, 1'b1, 32'h0));
        single_all("sub_ovf",   32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, pack_res(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF));
        single_all("adc_chain", 32'hFFFF_FFFF, 32'h0000_0000, OP_ADC, 1'b1, pack_res(1'b0, 1'b1, 1'b1, 32'h0));
        single_all("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, pack_res(1'b1, 1'b0, 1'b0, 32'h8000_0000));
        single_all("sbc_cin1",  32'h0000_0003, 32'h0000_0005, OP_SBC, 1'b1, pack_res(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE));
        single_all("sbc_cin0",  32'h0000_0005, 32'h0000_0003, OP_SBC, 1'b0, pack_res(1'b0, 1'b1, 1'b0, 32'h0000_0001));
        single_all("adc_cin0",  32'h0000_0001, 32'h0000_0001, OP_ADC, 1'b0, pack_res(1'b0, 1'b0, 1'b0, 32'h0000_0002));

        // Back-to-back stream of 16 ops
        got_q.delete(); cyc_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ra  = $urandom;
            rb  = $urandom;
            rop = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            drive(3'b001, ra, rb, rop, rc);
            @(negedge clk);
            check($sformatf("stream_in_ready_%0d", i), 64'(bus4.in_ready), 64'(1));
            exp_q.push_back(model(ra, rb, rop, rc));
        end
        @(posedge clk); #1;
        drive(3'b000, '0, '0, OP_ADD, 1'b0);
        for (int n = 0; n < 20 && got_q.size() < 16; n++) @(negedge clk);
        check("stream_count", 64'(got_q.size()), 64'(16));
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            check($sformatf("stream_res_%0d", i),   64'(got_q[i]), 64'(exp_q[i]));
            check($sformatf("stream_cycle_%0d", i), 64'(cyc_q[i] - cyc_q[0]), 64'(i));
        end

        // Backpressure: out_ready low for 6 cycles with in_valid held high
        got_q.delete(); cyc_q.delete(); exp_q.delete();
        sent      = 0;
        held_seen = 1'b0;
        held      = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus4.out_ready = 1'b0;
            drive(3'b001, 32'h1000_0000 + 32'(sent), 32'h11 * 32'(sent), OP_ADD, 1'b0);
            @(negedge clk);
            if (bus4.in_ready) begin
                exp_q.push_back(model(32'h1000_0000 + 32'(sent), 32'h11 * 32'(sent), OP_ADD, 1'b0));
                sent++;
            end
            if (bus4.out_valid) begin
                if (held_seen) check($sformatf("bp_hold_%0d", c), 64'(res4()), 64'(held));
                else begin
                    held      = res4();
                    held_seen = 1'b1;
                end
            end
        end
        check("bp_accepts",  64'(sent),           64'(4));
        check("bp_in_ready", 64'(bus4.in_ready),  64'(0));
        check("bp_out_valid", 64'(bus4.out_valid), 64'(1));
        if (exp_q.size() > 0) check("bp_head", 64'(held), 64'(exp_q[0]));
        for (int c = 0; c < 40 && sent < 8; c++) begin
            @(posedge clk); #1;
            bus4.out_ready = 1'b1;
            drive(3'b001, 32'h1000_0000 + 32'(sent), 32'h11 * 32'(sent), OP_ADD, 1'b0);
            @(negedge clk);
            if (bus4.in_ready) begin
                exp_q.push_back(model(32'h1000_0000 + 32'(sent), 32'h11 * 32'(sent), OP_ADD, 1'b0));
                sent++;
            end
        end
        @(posedge clk); #1;
        drive(3'b000, '0, '0, OP_ADD, 1'b0);
        for (int n = 0; n < 20 && got_q.size() < 8; n++) @(negedge clk);
        check("bp_count", 64'(got_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("bp_res_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        repeat (6) @(negedge clk);
        check("bp_no_dup", 64'(got_q.size()), 64'(8));

        // Reset with ops in flight
        got_q.delete(); cyc_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus4.out_ready  = 1'b0;
            bus1.out_ready  = 1'b0;
            bus32.out_ready = 1'b0;
            drive(3'b111, 32'hFFFF_FFF0 + 32'(i), 32'h20, OP_ADD, 1'b0);
        end
        @(posedge clk); #1;
        drive(3'b000, '0, '0, OP_ADD, 1'b0);
        @(posedge clk); #2;
        check("rst_pre_valid4", 64'(bus4.out_valid), 64'(1));
        check("rst_pre_valid1", 64'(bus1.out_valid), 64'(1));
        check("rst_pre_res4",   64'(res4()), 64'(pack_res(1'b0, 1'b1, 1'b0, 32'h0000_0010)));
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'({bus32.out_valid, bus1.out_valid, bus4.out_valid}), 64'(0));
        check("rst_async_res4",  64'(res4()),  64'(0));
        check("rst_async_res1",  64'(res1()),  64'(0));
        check("rst_async_res32", 64'(res32()), 64'(0));
        check("rst_async_ready", 64'({bus32.in_ready, bus1.in_ready, bus4.in_ready}), 64'(3'b111));
        @(negedge clk);
        rst_n = 1'b1;
        bus4.out_ready  = 1'b1;
        bus1.out_ready  = 1'b1;
        bus32.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_partial", 64'(got_q.size()), 64'(0));
        single_all("post_rst", 32'h0000_00FF, 32'h0000_0001, OP_ADD, 1'b0, pack_res(1'b0, 1'b0, 1'b0, 32'h0000_0100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
